rr_encoder4_2: RTL and testbench

- Registered 4-to-2 round-robin encoder: the encode direction of the team's 2-to-4 decoder.
- Accepts four request lines and selects one fairly. Emits the 2-bit index of the winner with a valid/ack handshake.
- Sits in front of a register-file or bus-select path, where the 2-bit index later feeds a 2-to-4 decoder. Decoding the index back must reproduce the granted request line.

---
 rtl/rr_enc_pkg.sv | 15 +
 rtl/rr_encoder4_2_if.sv | 30 +++
 rtl/dec2to4.sv | 20 ++
 rtl/rr_pick4.sv | 34 +++
 rtl/rr_encoder4_2.sv | 81 ++++++++
 tb/tb_rr_encoder4_2.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/rr_enc_pkg.sv
// Shared types and sizing for the 4-to-2 round-robin encoder.
package rr_enc_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = $clog2(NREQ);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [NREQ-1:0] req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_encoder4_2_if.sv
// Request/grant bundle between requesters and the round-robin encoder.
interface rr_encoder4_2_if;
  import rr_enc_pkg::*;

  req_t req;
  logic ack;
  idx_t grant_idx;
  logic grant_valid;
  req_t grant_onehot;
  logic any_req;

  modport master (
    output req,
    output ack,
    input  grant_idx,
    input  grant_valid,
    input  grant_onehot,
    input  any_req
  );

  modport slave (
    input  req,
    input  ack,
    output grant_idx,
    output grant_valid,
    output grant_onehot,
    output any_req
  );

endinterface

// File: rtl/dec2to4.sv
// 2-to-4 decoder with enable; all outputs low when disabled.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      case (sel)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        default: y = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request scanning circularly from ptr.
module rr_pick4
  import rr_enc_pkg::*;
(
  input  req_t req,
  input  idx_t ptr,
  output idx_t win_idx,
  output logic win_found
);

  logic [2*NREQ-1:0] dbl;
  req_t rot;
  idx_t off;

  // Rotating right by ptr puts requester ptr at bit 0, so a fixed
  // lowest-bit-first encode gives the circular scan order.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: NREQ];
  end

  always_comb begin
    off = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (rot[i-1]) begin
        off = idx_t'(i - 1);
      end
    end
  end

  assign win_idx   = off + ptr;
  assign win_found = |req;

endmodule

// File: rtl/rr_encoder4_2.sv
// Registered 4-to-2 round-robin encoder with sticky grant and valid/ack handshake.
module rr_encoder4_2
  import rr_enc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rr_encoder4_2_if.slave    bus
);

  state_t state_q, state_d;
  idx_t   ptr_q, ptr_d;
  idx_t   idx_q, idx_d;
  logic   valid_q, valid_d;
  logic   any_q;

  idx_t   win_idx;
  logic   win_found;

  rr_pick4 u_pick (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_idx   (win_idx),
    .win_found (win_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      any_q   <= |bus.req;
    end
  end

  // The grant only ends on ack, so the index after an accepted grant
  // seeds the next scan and forces one IDLE cycle between grants.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          ptr_d   = idx_q + idx_t'(1);
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  dec2to4 u_dec (
    .en  (valid_q),
    .sel (idx_q),
    .y   (bus.grant_onehot)
  );

  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.any_req     = any_q;

endmodule

// File: tb/tb_rr_encoder4_2.sv
// Directed bench for rr_encoder4_2 with a scoreboard of expected grant indices.
module tb_rr_encoder4_2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_q[$];
  logic prev_valid;
  logic [1:0] held_idx;

  rr_encoder4_2_if ifc ();

  rr_encoder4_2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: every new grant consumes one scoreboard entry; held grants must not move.
  initial begin
    prev_valid = 1'b0;
    held_idx   = '0;
    forever begin
      @(negedge clk);
      if (ifc.grant_valid === 1'b1) begin
        chk("onehot_matches_idx", ifc.grant_onehot, 32'h1 << ifc.grant_idx);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 1, 0);
          end else begin
            chk("grant_idx", ifc.grant_idx, exp_q.pop_front());
          end
          held_idx = ifc.grant_idx;
        end else begin
          chk("grant_held", ifc.grant_idx, held_idx);
        end
      end else begin
        chk("onehot_zero_when_idle", ifc.grant_onehot, 0);
        chk("valid_known_low", ifc.grant_valid, 0);
      end
      prev_valid = (ifc.grant_valid === 1'b1);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ifc.req  = '0;
    ifc.ack  = 1'b0;

    // Reset then idle
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_valid", ifc.grant_valid, 0);
      chk("idle_onehot", ifc.grant_onehot, 4'b0000);
      chk("idle_any_req", ifc.any_req, 0);
    end

    // Single request, held without ack
    ifc.req = 4'b0100; exp_q.push_back(2);
    cyc();
    chk("single_valid", ifc.grant_valid, 1);
    chk("single_onehot", ifc.grant_onehot, 4'b0100);
    chk("single_any_req", ifc.any_req, 1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("single_hold_valid", ifc.grant_valid, 1);
      chk("single_hold_idx", ifc.grant_idx, 2);
    end
    ifc.ack = 1'b1; ifc.req = '0;
    cyc();
    chk("single_released", ifc.grant_valid, 0);
    ifc.ack = 1'b0;

    // Pointer skip: ptr=3, req=0011 -> 0, then 1
    ifc.req = 4'b0011; exp_q.push_back(0);
    cyc();
    chk("skip_valid0", ifc.grant_valid, 1);
    ifc.ack = 1'b1; exp_q.push_back(1);
    cyc();
    chk("skip_bubble", ifc.grant_valid, 0);
    ifc.ack = 1'b0;
    cyc();
    chk("skip_valid1", ifc.grant_valid, 1);
    ifc.ack = 1'b1; ifc.req = '0;
    cyc();
    ifc.ack = 1'b0;

    // Round-robin with wrap from a fresh reset, ack held high
    reset = 1'b1;
    cyc();
    reset = 1'b0; ifc.req = 4'b1111; ifc.ack = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("rr_valid_pattern", ifc.grant_valid, (k % 2 == 1) ? 1 : 0);
      if (k == 1) chk("rr_any_req", ifc.any_req, 1);
    end
    ifc.req = '0; ifc.ack = 1'b0;

    // Sticky grant (ptr=2, req=0010 -> 1), then ack ignored in IDLE
    ifc.req = 4'b0010; exp_q.push_back(1);
    cyc();
    chk("sticky_valid", ifc.grant_valid, 1);
    ifc.req = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sticky_hold_valid", ifc.grant_valid, 1);
      chk("sticky_hold_idx", ifc.grant_idx, 1);
      if (i == 0) chk("any_req_dropped", ifc.any_req, 0);
    end
    ifc.ack = 1'b1;
    cyc();
    chk("sticky_released", ifc.grant_valid, 0);
    ifc.ack = 1'b0;
    ifc.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("idle_ack_ignored", ifc.grant_valid, 0);
    end
    ifc.ack = 1'b0;

    // Reset mid-grant (ptr=2, req=1000 -> 3)
    ifc.req = 4'b1000; exp_q.push_back(3);
    cyc();
    chk("pre_reset_valid", ifc.grant_valid, 1);
    chk("pre_reset_idx", ifc.grant_idx, 3);
    reset = 1'b1; ifc.req = '0;
    cyc();
    chk("abort_valid", ifc.grant_valid, 0);
    chk("abort_idx", ifc.grant_idx, 0);
    chk("abort_onehot", ifc.grant_onehot, 0);
    chk("abort_any_req", ifc.any_req, 0);
    reset = 1'b0; ifc.req = 4'b1000; exp_q.push_back(3);
    cyc();
    chk("post_reset_valid", ifc.grant_valid, 1);
    chk("post_reset_onehot", ifc.grant_onehot, 4'b1000);
    ifc.ack = 1'b1; ifc.req = '0;
    cyc();
    ifc.ack = 1'b0;
    cyc(); cyc();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
